// File: rtl/iob_iob2axil_ot.sv
`default_nettype none
// ============================================================================
// Module   : iob_iob2axil_ot
// Function : IOb native master to AXI-Lite master bridge with up to MAX_OT
//            outstanding transactions per direction. Reads and writes never
//            overlap, so responses cannot be reordered between directions.
//            Write responses are absorbed; read data is passed straight back.
// Revision : 1.0 - initial release
// ============================================================================
module iob_iob2axil_ot #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_OT = 4
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  // IOb slave side
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  input  logic                iob_rready_i,
  // AXI-Lite write address
  output logic                axil_awvalid_o,
  input  logic                axil_awready_i,
  output logic [ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]          axil_awprot_o,
  // AXI-Lite write data
  output logic                axil_wvalid_o,
  input  logic                axil_wready_i,
  output logic [DATA_W-1:0]   axil_wdata_o,
  output logic [DATA_W/8-1:0] axil_wstrb_o,
  // AXI-Lite write response
  input  logic                axil_bvalid_i,
  output logic                axil_bready_o,
  input  logic [1:0]          axil_bresp_i,
  // AXI-Lite read address
  output logic                axil_arvalid_o,
  input  logic                axil_arready_i,
  output logic [ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]          axil_arprot_o,
  // AXI-Lite read data
  input  logic                axil_rvalid_i,
  output logic                axil_rready_o,
  input  logic [DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]          axil_rresp_i,
  // status
  output logic                err_o,
  input  logic                err_clr_i,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(MAX_OT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = '0;

  logic [CNT_W-1:0] wr_cnt, wr_cnt_nxt;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_nxt;
  logic             aw_done, w_done;
  logic             is_write, wr_req, rd_req;
  logic             wr_ok, rd_ok;
  logic             aw_hs, w_hs, ar_hs, r_hs;
  logic             wr_complete;
  logic             err_set;

  // Request decode, issue gating and AXI channel drive
  always_comb begin
    is_write = |iob_wstrb_i;
    wr_req   = iob_valid_i & is_write;
    rd_req   = iob_valid_i & ~is_write;

    // A direction may only issue while the other direction is fully drained
    wr_ok = (wr_cnt < MAX_CNT) & (rd_cnt == ZERO_CNT);
    rd_ok = (rd_cnt < MAX_CNT) & (wr_cnt == ZERO_CNT);

    axil_awvalid_o = wr_req & wr_ok & ~aw_done;
    axil_wvalid_o  = wr_req & wr_ok & ~w_done;
    axil_awaddr_o  = iob_addr_i;
    axil_wdata_o   = iob_wdata_i;
    axil_wstrb_o   = iob_wstrb_i;
    axil_awprot_o  = 3'b000;

    axil_arvalid_o = rd_req & rd_ok;
    axil_araddr_o  = iob_addr_i;
    axil_arprot_o  = 3'b000;

    axil_bready_o  = 1'b1;

    iob_rvalid_o   = axil_rvalid_i;
    iob_rdata_o    = axil_rdata_i;
    axil_rready_o  = iob_rready_i;

    aw_hs = axil_awvalid_o & axil_awready_i;
    w_hs  = axil_wvalid_o & axil_wready_i;
    ar_hs = axil_arvalid_o & axil_arready_i;
    r_hs  = axil_rvalid_i & iob_rready_i;

    // The write is accepted once both AW and W have been taken by the slave
    wr_complete = wr_req & wr_ok & (aw_done | aw_hs) & (w_done | w_hs);
    iob_ready_o = wr_complete | ar_hs;

    err_set = (axil_bvalid_i & (axil_bresp_i != 2'b00)) |
              (r_hs & (axil_rresp_i != 2'b00));

    busy_o = (wr_cnt != ZERO_CNT) | (rd_cnt != ZERO_CNT) | aw_done | w_done;
  end

  // Outstanding-count update; simultaneous inc/dec cancels, decrement saturates at 0
  always_comb begin
    wr_cnt_nxt = wr_cnt;
    rd_cnt_nxt = rd_cnt;
    case ({wr_complete, axil_bvalid_i})
      2'b10:   wr_cnt_nxt = wr_cnt + ONE_CNT;
      2'b01:   wr_cnt_nxt = (wr_cnt == ZERO_CNT) ? ZERO_CNT : wr_cnt - ONE_CNT;
      default: wr_cnt_nxt = wr_cnt;
    endcase
    case ({ar_hs, r_hs})
      2'b10:   rd_cnt_nxt = rd_cnt + ONE_CNT;
      2'b01:   rd_cnt_nxt = (rd_cnt == ZERO_CNT) ? ZERO_CNT : rd_cnt - ONE_CNT;
      default: rd_cnt_nxt = rd_cnt;
    endcase
  end

  // State registers: counters, half-done write flags and sticky error
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        wr_cnt  <= ZERO_CNT;
        rd_cnt  <= ZERO_CNT;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        err_o   <= 1'b0;
      end else begin
        wr_cnt <= wr_cnt_nxt;
        rd_cnt <= rd_cnt_nxt;
        if (wr_complete) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        if (err_set)        err_o <= 1'b1;
        else if (err_clr_i) err_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_iob2axil_ot.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_iob2axil_ot
// Function : Self-checking bench for iob_iob2axil_ot: directed scenarios plus
//            randomized traffic against an AXI-Lite memory slave, with read
//            data checked through an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_iob2axil_ot;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAX_OT = 4;
  localparam int N_TRANS = 300;

  logic        clk = 1'b0;
  logic        cke, rst;
  logic        iob_valid, iob_ready, iob_rvalid, iob_rready;
  logic [31:0] iob_addr, iob_wdata, iob_rdata;
  logic [3:0]  iob_wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic [1:0]  bresp, rresp;
  logic        err, err_clr, busy;

  always #5 clk = ~clk;

  iob_iob2axil_ot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OT(MAX_OT)) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
    .iob_valid_i(iob_valid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
    .iob_wstrb_i(iob_wstrb), .iob_ready_o(iob_ready), .iob_rvalid_o(iob_rvalid),
    .iob_rdata_o(iob_rdata), .iob_rready_i(iob_rready),
    .axil_awvalid_o(awvalid), .axil_awready_i(awready), .axil_awaddr_o(awaddr),
    .axil_awprot_o(awprot),
    .axil_wvalid_o(wvalid), .axil_wready_i(wready), .axil_wdata_o(wdata),
    .axil_wstrb_o(wstrb),
    .axil_bvalid_i(bvalid), .axil_bready_o(bready), .axil_bresp_i(bresp),
    .axil_arvalid_o(arvalid), .axil_arready_i(arready), .axil_araddr_o(araddr),
    .axil_arprot_o(arprot),
    .axil_rvalid_i(rvalid), .axil_rready_o(rready), .axil_rdata_i(rdata),
    .axil_rresp_i(rresp),
    .err_o(err), .err_clr_i(err_clr), .busy_o(busy)
  );

  int          total = 0;
  int          bad = 0;
  bit          done = 1'b0;
  logic [31:0] ref_mem[8];
  logic [31:0] slv_mem[8];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // drive point just after the active edge; sample point on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- random
  task automatic master_run();
    bit          wr, acc;
    logic [2:0]  idx;
    int          cyc;
    for (int i = 0; i < N_TRANS; i++) begin
      wr  = ($urandom_range(0, 1) == 1);
      idx = 3'($urandom_range(0, 7));
      iob_valid = 1'b1;
      iob_addr  = {27'd0, idx, 2'b00};
      iob_wdata = $urandom;
      iob_wstrb = wr ? 4'($urandom_range(1, 15)) : 4'h0;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 200) begin
        smp();
        if (iob_ready) begin
          acc = 1'b1;
          if (wr) ref_mem[idx] = merge(ref_mem[idx], iob_wdata, iob_wstrb);
          else    exp_q.push_back(ref_mem[idx]);
        end
        tick();
        cyc++;
      end
      if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
      iob_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    acc = 1'b0;
    for (int c = 0; c < 1000 && !acc; c++) begin
      smp();
      if (exp_q.size() == 0 && !busy) acc = 1'b1;
      else tick();
    end
    chk("drain", 64'(acc), 64'd1);
    done = 1'b1;
  endtask

  task automatic slave_run();
    logic [31:0] awq[$];
    logic [35:0] wq[$];
    logic [31:0] rq[$];
    int          bcnt = 0;
    logic        awhs, whs, arhs, bfire, rfire;
    logic [31:0] aa, wd, ra, a;
    logic [3:0]  ws;
    logic [35:0] wv;
    while (!done) begin
      smp();
      awhs  = awvalid & awready;
      whs   = wvalid & wready;
      arhs  = arvalid & arready;
      bfire = bvalid & bready;
      rfire = rvalid & rready;
      aa = awaddr; wd = wdata; ws = wstrb; ra = araddr;
      tick();
      if (awhs) awq.push_back(aa);
      if (whs)  wq.push_back({ws, wd});
      while (awq.size() > 0 && wq.size() > 0) begin
        a  = awq.pop_front();
        wv = wq.pop_front();
        slv_mem[a[4:2]] = merge(slv_mem[a[4:2]], wv[31:0], wv[35:32]);
        bcnt++;
      end
      if (bfire) bcnt--;
      if (arhs) rq.push_back(slv_mem[ra[4:2]]);
      if (rfire) void'(rq.pop_front());
      awready = ($urandom_range(0, 2) != 0);
      wready  = ($urandom_range(0, 2) != 0);
      arready = ($urandom_range(0, 2) != 0);
      bvalid  = (bcnt > 0) && ($urandom_range(0, 1) == 1);
      rvalid  = (rq.size() > 0) && ($urandom_range(0, 1) == 1);
      rdata   = rvalid ? rq[0] : $urandom;
    end
    awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
  endtask

  task automatic monitor_run();
    logic [31:0] e;
    while (!done) begin
      smp();
      if (iob_rvalid && iob_rready) begin
        if (exp_q.size() == 0) chk("unexpected_rdata", 64'(iob_rvalid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("rdata", 64'(iob_rdata), 64'(e));
        end
      end
      tick();
      iob_rready = ($urandom_range(0, 3) != 0);
    end
    iob_rready = 1'b1;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    int cnt;
    cke = 1'b1; rst = 1'b1; iob_valid = 1'b0; iob_addr = '0; iob_wdata = '0;
    iob_wstrb = '0; iob_rready = 1'b0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; arready = 1'b0; rvalid = 1'b0; rdata = '0;
    rresp = 2'b00; err_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    smp();
    chk("rst_ready", 64'(iob_ready), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_bready", 64'(bready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("prot", 64'({awprot, arprot}), 64'd0);

    // zero-wait write
    tick();
    iob_valid = 1'b1; iob_addr = 32'h10; iob_wdata = 32'hDEADBEEF; iob_wstrb = 4'hF;
    awready = 1'b1; wready = 1'b1;
    smp();
    chk("zw_ready", 64'(iob_ready), 64'd1);
    chk("zw_awaddr", 64'(awaddr), 64'h10);
    chk("zw_wdata", 64'(wdata), 64'hDEADBEEF);
    chk("zw_wstrb", 64'(wstrb), 64'hF);
    tick();
    iob_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    smp();
    chk("zw_busy1", 64'(busy), 64'd1);
    chk("zw_ready_idle", 64'(iob_ready), 64'd0);
    tick();
    bvalid = 1'b0;
    smp();
    chk("zw_busy0", 64'(busy), 64'd0);

    // W accepted two cycles before AW
    tick();
    iob_valid = 1'b1; iob_addr = 32'h20; iob_wstrb = 4'h3; wready = 1'b1;
    smp();
    chk("wf_wvalid", 64'(wvalid), 64'd1);
    chk("wf_ready0", 64'(iob_ready), 64'd0);
    tick();
    wready = 1'b0;
    smp();
    chk("wf_wvalid_drop", 64'(wvalid), 64'd0);
    chk("wf_awvalid", 64'(awvalid), 64'd1);
    chk("wf_busy", 64'(busy), 64'd1);
    chk("wf_ready1", 64'(iob_ready), 64'd0);
    tick();
    smp();
    chk("wf_awvalid2", 64'(awvalid), 64'd1);
    tick();
    awready = 1'b1;
    smp();
    chk("wf_ready_aw", 64'(iob_ready), 64'd1);
    tick();
    iob_valid = 1'b0; awready = 1'b0; bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    smp();
    chk("wf_busy0", 64'(busy), 64'd0);

    // MAX_OT read limit
    tick();
    iob_valid = 1'b1; iob_addr = 32'h30; iob_wstrb = 4'h0; arready = 1'b1; iob_rready = 1'b1;
    cnt = 0;
    repeat (MAX_OT) begin
      smp();
      if (iob_ready) cnt++;
      tick();
    end
    chk("ot_ar_count", 64'(cnt), 64'(MAX_OT));
    smp();
    chk("ot_block_arvalid", 64'(arvalid), 64'd0);
    chk("ot_block_ready", 64'(iob_ready), 64'd0);
    tick();
    rvalid = 1'b1;
    smp();
    chk("ot_block_arvalid2", 64'(arvalid), 64'd0);
    tick();
    rvalid = 1'b0;
    smp();
    chk("ot_resume_arvalid", 64'(arvalid), 64'd1);
    chk("ot_resume_ready", 64'(iob_ready), 64'd1);
    tick();
    iob_valid = 1'b0; arready = 1'b0; rvalid = 1'b1;
    repeat (MAX_OT) tick();
    rvalid = 1'b0;
    smp();
    chk("ot_busy0", 64'(busy), 64'd0);

    // read waits for outstanding write
    tick();
    iob_valid = 1'b1; iob_addr = 32'h40; iob_wstrb = 4'hF; awready = 1'b1; wready = 1'b1;
    smp();
    chk("rw_wr_ready", 64'(iob_ready), 64'd1);
    tick();
    iob_wstrb = 4'h0; awready = 1'b0; wready = 1'b0; arready = 1'b1;
    smp();
    chk("rw_arvalid0", 64'(arvalid), 64'd0);
    tick();
    bvalid = 1'b1;
    smp();
    chk("rw_arvalid_b", 64'(arvalid), 64'd0);
    tick();
    bvalid = 1'b0;
    smp();
    chk("rw_arvalid1", 64'(arvalid), 64'd1);
    tick();
    iob_valid = 1'b0; arready = 1'b0; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;

    // error flag
    iob_valid = 1'b1; iob_addr = 32'h50; arready = 1'b1;
    smp();
    chk("er_ar_ready", 64'(iob_ready), 64'd1);
    tick();
    iob_valid = 1'b0; arready = 1'b0; rvalid = 1'b1; rresp = 2'b10;
    smp();
    chk("er_before", 64'(err), 64'd0);
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    smp();
    chk("er_set", 64'(err), 64'd1);
    tick();
    smp();
    chk("er_sticky", 64'(err), 64'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    smp();
    chk("er_clr", 64'(err), 64'd0);
    tick();
    bvalid = 1'b1; bresp = 2'b11; err_clr = 1'b1;
    tick();
    bvalid = 1'b0; bresp = 2'b00; err_clr = 1'b0;
    smp();
    chk("er_set_wins", 64'(err), 64'd1);
    chk("er_sat_busy", 64'(busy), 64'd0);

    // reset mid-transaction
    tick();
    iob_valid = 1'b1; iob_addr = 32'h60; iob_wstrb = 4'hF; awready = 1'b1; wready = 1'b1;
    repeat (3) tick();
    wready = 1'b0;
    smp();
    chk("rs_ready0", 64'(iob_ready), 64'd0);
    tick();
    awready = 1'b0;
    smp();
    chk("rs_awdone", 64'(awvalid), 64'd0);
    chk("rs_wvalid", 64'(wvalid), 64'd1);
    chk("rs_busy1", 64'(busy), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    smp();
    chk("rs_busy0", 64'(busy), 64'd0);
    chk("rs_err0", 64'(err), 64'd0);
    chk("rs_awvalid", 64'(awvalid), 64'd1);
    tick();
    iob_valid = 1'b0;

    // clock enable low: outputs follow, state holds
    cke = 1'b0;
    iob_valid = 1'b1; iob_addr = 32'h70; awready = 1'b1; wready = 1'b1;
    smp();
    chk("ck_ready_comb", 64'(iob_ready), 64'd1);
    tick();
    iob_valid = 1'b0; awready = 1'b0; wready = 1'b0; cke = 1'b1;
    smp();
    chk("ck_hold_busy", 64'(busy), 64'd0);

    // randomized traffic
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    iob_rready = 1'b1;
    fork
      master_run();
      slave_run();
      monitor_run();
    join
    smp();
    chk("final_err", 64'(err), 64'd0);
    chk("final_busy", 64'(busy), 64'd0);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/iob_iob2axil_ot.md
IOB_IOB2AXIL_OT -- requirements
Module: iob_iob2axil_ot

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI-Lite and IOb address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values are 32 and 64.
REQ-003 SHALL have parameter MAX_OT, default 4, maximum outstanding transactions per direction; legal values are 1 to 16.
REQ-004 SHALL have ports as follows; all names, widths and meanings below are fixed:
  clk_i  in  1  clock.
  cke_i  in  1  clock enable; all state holds when 0.
  rst_i  in  1  reset; synchronous, active-high.
  iob_valid_i  in  1  request valid.
  iob_addr_i  in  ADDR_W  address.
  iob_wdata_i  in  DATA_W  write data.
  iob_wstrb_i  in  DATA_W/8  byte strobes; nonzero means write, zero means read.
  iob_ready_o  out  1  request accepted.
  iob_rvalid_o  out  1  read data valid.
  iob_rdata_o  out  DATA_W  read data.
  iob_rready_i  in  1  read data accepted.
  axil_aw*  valid/ready/addr  AXI-Lite write address channel.
  axil_w*  valid/ready/data/strb  AXI-Lite write data channel.
  axil_b*  valid/ready/resp[2]  AXI-Lite write response channel.
  axil_ar*  valid/ready/addr  AXI-Lite read address channel.
  axil_r*  valid/ready/data/resp[2]  AXI-Lite read data channel.
  axil_awprot_o and axil_arprot_o  out  3  tied to 3'b000.
  err_o  out  1  sticky error: a non-OKAY BRESP or RRESP was received.
  err_clr_i  in  1  clears err_o.
  busy_o  out  1  one or more transactions outstanding.

Function
REQ-005 SHALL treat an IOb write as a request with valid=1 and |wstrb=1; SHALL treat a read as valid=1 and wstrb=0. The master holds addr/wdata/wstrb stable until ready.
REQ-006 SHALL keep two counters, wr_cnt and rd_cnt, each $clog2(MAX_OT+1) bits wide.
REQ-007 SHALL define wr_ok = (wr_cnt<MAX_OT) & (rd_cnt==0) and rd_ok = (rd_cnt<MAX_OT) & (wr_cnt==0); this prevents read/write reordering.
REQ-008 Write issue: awvalid_o = valid & write & wr_ok & ~aw_done; wvalid_o = valid & write & wr_ok & ~w_done; awaddr=addr, wdata=wdata, wstrb=wstrb combinational.
REQ-009 SHALL register aw_done and w_done; each sets on its handshake while the other is still pending. Both clear when the write completes.
REQ-010 A write completes in the cycle where (aw_done|awhs) & (w_done|whs); in that cycle iob_ready_o=1, wr_cnt increments, and both flags clear. AW and W in the same cycle gives 0-wait-state completion.
REQ-011 Read issue: arvalid_o = valid & read & rd_ok; araddr=addr; iob_ready_o = arready_i in that cycle; rd_cnt increments on the AR handshake.
REQ-012 iob_ready_o SHALL be 0 in every other case, including valid=0 and blocked by wr_ok/rd_ok.
REQ-013 bready_o SHALL be constant 1; wr_cnt SHALL decrement on each bvalid_i; write responses SHALL never reach the IOb side.
REQ-014 Read data: iob_rvalid_o=rvalid_i, iob_rdata_o=rdata_i, rready_o=iob_rready_i; rd_cnt SHALL decrement on the R handshake.
REQ-015 Simultaneous increment and decrement on the same counter SHALL leave it unchanged. No overflow: issue is blocked at MAX_OT. A response with counter==0 is a slave protocol violation; the counter SHALL saturate at 0.
REQ-016 err_o SHALL set on bvalid with bresp!=2'b00, or on an R handshake with rresp!=2'b00. err_clr_i SHALL clear it; if set and clear occur in the same cycle, set wins.
REQ-017 busy_o = (wr_cnt!=0)|(rd_cnt!=0)|aw_done|w_done.
REQ-018 If valid drops while aw_done^w_done, behaviour is undefined; the master must not do this.
REQ-019 When cke_i=0, registers SHALL hold; combinational outputs still follow their inputs.

Reset
REQ-020 rst_i=1 at a clock edge (with cke_i=1) SHALL clear wr_cnt, rd_cnt, aw_done, w_done and err_o.
REQ-021 After reset, outputs SHALL be: iob_ready_o=0; awvalid/wvalid/arvalid=0 while valid=0; bready_o=1; busy_o=0.
REQ-022 Reset mid-transaction SHALL abandon outstanding transactions; the AXI slave must be reset in the same cycle.

Verification
REQ-023 Write, AW and W ready same cycle: addr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> iob_ready_o=1 that cycle; wr_cnt=1; bvalid next cycle -> wr_cnt=0, busy_o=0.
REQ-024 Write, W ready 2 cycles before AW: wvalid drops after the W handshake; awvalid stays until the AW handshake; iob_ready_o=1 only in the AW handshake cycle.
REQ-025 MAX_OT=4, 5 back-to-back reads with rvalid withheld -> 4 AR handshakes; 5th arvalid=0 until the first R handshake, then it issues.
REQ-026 Read issued with wr_cnt=1 outstanding -> arvalid=0 until bvalid; then AR issues in the following cycle.
REQ-027 rresp=2'b10 on a read -> err_o=1 next cycle and stays 1; err_clr_i pulse -> err_o=0; simultaneous bresp=2'b11 and err_clr_i -> err_o stays 1.
REQ-028 rst_i asserted with wr_cnt=3 and aw_done=1 -> next cycle all counters and flags 0, busy_o=0, err_o=0.
